// File: rtl/mac_frame_pkg.sv
// mac_frame_pkg: shared types, default widths and the round/saturate helper
// for the frame accumulator.
//   state_t       : frame FSM states (IDLE, ACC)
//   *_DEF         : default widths used as parameter defaults by the top
//   ROUND         : half-LSB rounding constant 2^(SHIFT_DEF-1)
//   sat_round()   : round-half-up, arithmetic shift, saturate -> {sat, data}
package mac_frame_pkg;

  localparam int unsigned PW_DEF     = 48;
  localparam int unsigned AW_ACC_DEF = 56;
  localparam int unsigned OW_DEF     = 16;
  localparam int unsigned SHIFT_DEF  = 15;
  localparam int unsigned LW_DEF     = 8;

  localparam logic signed [AW_ACC_DEF:0] ROUND =
    {{AW_ACC_DEF{1'b0}}, 1'b1} << (SHIFT_DEF - 1);

  // Saturation bounds held at AW_ACC_DEF+1 bits; the minimum is the
  // bitwise complement of the maximum (-2^(OW-1) == ~(2^(OW-1)-1)).
  localparam logic signed [AW_ACC_DEF:0] SAT_MAX =
    ({{AW_ACC_DEF{1'b0}}, 1'b1} << (OW_DEF - 1)) - 1;
  localparam logic signed [AW_ACC_DEF:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // The rounding add is done one bit wider than the accumulator so that
  // adding the half-LSB to the most positive sum cannot wrap.
  function automatic logic [OW_DEF:0] sat_round(
    input logic signed [AW_ACC_DEF-1:0] s,
    input int unsigned                  shift
  );
    logic signed [AW_ACC_DEF:0] ext;
    logic signed [AW_ACC_DEF:0] rnd;
    logic signed [AW_ACC_DEF:0] r;
    logic                       sat;
    logic [OW_DEF-1:0]          data;
    ext = {s[AW_ACC_DEF-1], s};
    rnd = (AW_ACC_DEF + 1)'(1) << (shift - 1);
    r   = (ext + rnd) >>> shift;
    if (r > SAT_MAX) begin
      sat  = 1'b1;
      data = SAT_MAX[OW_DEF-1:0];
    end else if (r < SAT_MIN) begin
      sat  = 1'b1;
      data = SAT_MIN[OW_DEF-1:0];
    end else begin
      sat  = 1'b0;
      data = r[OW_DEF-1:0];
    end
    return {sat, data};
  endfunction

endpackage

// File: rtl/mac_out_fifo2.sv
// mac_out_fifo2: 2-entry first-in/first-out buffer, head-of-queue visible.
//   clk, rst   : clock, synchronous active-high reset (empties, clears data)
//   push       : write push_data (caller guarantees occ < 2)
//   push_data  : entry to append
//   pop        : drop head entry (caller guarantees occ > 0)
//   head       : oldest entry
//   occ        : number of valid entries (0..2)
module mac_out_fifo2 #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  // e0 is always the head; e1 is the second entry when occ == 2.
  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, new entry goes
          // behind whatever survives the pop.
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;
  assign occ  = cnt;

endmodule

// File: rtl/mac_frame_accum.sv
// mac_frame_accum: accumulates a frame of signed products, rounds and
// scales the sum, saturates it to an output sample and buffers it.
//   clk, rst   : clock, synchronous active-high reset
//   in_vld     : din valid
//   in_rdy     : block can accept din (output buffer not full)
//   din        : signed product from the multiply-add stage
//   frame_len  : samples per frame, sampled on the first beat (0 acts as 1)
//   out_vld    : out_data/out_sat valid
//   out_rdy    : downstream accepts the current sample
//   out_data   : signed rounded/saturated frame sum
//   out_sat    : out_data was clipped
//   busy       : a frame is partially accumulated
module mac_frame_accum
  import mac_frame_pkg::*;
#(
  parameter int unsigned PW     = PW_DEF,
  parameter int unsigned AW_ACC = AW_ACC_DEF,
  parameter int unsigned OW     = OW_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF,
  parameter int unsigned LW     = LW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic signed [PW-1:0] din,
  input  logic [LW-1:0]        frame_len,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [OW-1:0]        out_data,
  output logic                 out_sat,
  output logic                 busy
);

  state_t                    state, state_d;
  logic signed [AW_ACC-1:0]  acc, acc_d, acc_next, din_ext;
  logic [LW-1:0]             cnt, cnt_d, len, len_d, len_in;
  logic                      accept;
  logic                      push, pop;
  logic [OW:0]               push_data;
  logic [OW:0]               head;
  logic [1:0]                occ;

  assign in_rdy  = (occ < 2'd2);
  assign accept  = in_vld && in_rdy;
  assign out_vld = (occ != 2'd0);
  assign pop     = out_vld && out_rdy;
  assign busy    = (state == ACC);

  assign din_ext = AW_ACC'(din);
  assign len_in  = (frame_len == '0) ? LW'(1) : frame_len;

  // The completing beat's sum is formed combinationally so the result can
  // be pushed on the same edge that accepts the last beat.
  assign acc_next  = ((state == ACC) ? acc : '0) + din_ext;
  assign push_data = sat_round(acc_next, SHIFT);

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    len_d   = len;
    push    = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          len_d = len_in;
          if (len_in == LW'(1)) begin
            push = 1'b1;
          end else begin
            acc_d   = acc_next;
            cnt_d   = LW'(1);
            state_d = ACC;
          end
        end
        ACC: begin
          if (cnt == len - LW'(1)) begin
            push    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      len   <= len_d;
    end
  end

  mac_out_fifo2 #(
    .W(OW + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign out_sat  = head[OW];
  assign out_data = head[OW-1:0];

endmodule

// File: tb/tb_mac_frame_accum.sv
// Self-checking bench for mac_frame_accum: directed cases with literal
// expectations plus randomized frames checked against a behavioural model
// (frame sums in plain integer arithmetic, output buffer as a queue).
module tb_mac_frame_accum;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_vld = 1'b0;
  logic               in_rdy;
  logic signed [47:0] din = '0;
  logic [7:0]         frame_len = 8'd1;
  logic               out_vld;
  logic               out_rdy = 1'b1;
  logic [15:0]        out_data;
  logic               out_sat;
  logic               busy;

  always #5 clk = ~clk;

  mac_frame_accum #(
    .PW(48), .AW_ACC(56), .OW(16), .SHIFT(15), .LW(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .din       (din),
    .frame_len (frame_len),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  typedef struct packed {
    logic        sat;
    logic [15:0] data;
  } res_t;

  res_t   exp_q[$];
  res_t   got_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     rnd_rdy = 1'b0;
  bit     m_busy = 1'b0;
  int     m_cnt = 0;
  int     m_len = 0;
  longint m_sum = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endfunction

  // Frame result from the arithmetic definition: wrap to 56 bits,
  // round half up, divide by 2^15, clip to the 16-bit signed range.
  function automatic res_t ref_result(input longint s);
    longint w;
    longint r;
    res_t   rr;
    w = (s <<< 8) >>> 8;
    r = (w + 64'sd16384) >>> 15;
    if (r > 32767) begin
      rr.sat = 1'b1; rr.data = 16'h7fff;
    end else if (r < -32768) begin
      rr.sat = 1'b1; rr.data = 16'h8000;
    end else begin
      rr.sat = 1'b0; rr.data = r[15:0];
    end
    return rr;
  endfunction

  function automatic void model_beat(input longint d, input int fl);
    if (!m_busy) begin
      m_len = (fl == 0) ? 1 : fl;
      m_sum = d;
      m_cnt = 1;
      if (m_len == 1) exp_q.push_back(ref_result(m_sum));
      else            m_busy = 1'b1;
    end else begin
      m_sum += d;
      m_cnt++;
      if (m_cnt == m_len) begin
        exp_q.push_back(ref_result(m_sum));
        m_busy = 1'b0;
      end
    end
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
    end else begin
      chk("out_vld", longint'(out_vld), longint'(exp_q.size() != 0));
      chk("in_rdy", longint'(in_rdy), longint'(exp_q.size() < 2));
      chk("busy", longint'(busy), longint'(m_busy));
      if (out_vld && exp_q.size() != 0) begin
        chk("out_data", longint'(signed'(out_data)), longint'(signed'(exp_q[0].data)));
        chk("out_sat", longint'(out_sat), longint'(exp_q[0].sat));
      end
      if (out_vld && out_rdy) begin
        got_q.push_back({out_sat, out_data});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_vld && in_rdy) model_beat(longint'(din), int'(frame_len));
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input longint d, input int fl);
    int t;
    t = 0;
    in_vld    = 1'b1;
    din       = d[47:0];
    frame_len = fl[7:0];
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      t++;
      if (t > 300) begin
        timeout("beat_accept");
        break;
      end
    end
    sync();
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n);
    int t;
    t = 0;
    while (got_q.size() < n) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        timeout("wait_result");
        break;
      end
    end
    sync();
  endtask

  task automatic lit(input string name, input int idx, input int data, input int sat);
    if (got_q.size() > idx) begin
      chk({name, "_data"}, longint'(signed'(got_q[idx].data)), longint'(data));
      chk({name, "_sat"}, longint'(got_q[idx].sat), longint'(sat));
    end else begin
      timeout({name, "_missing"});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]        raw;
    logic signed [47:0] r48;
    longint             d;
    int                 fl, nb, t;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_vld", longint'(out_vld), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_rdy", longint'(in_rdy), 1);
    sync();

    // Single-beat frames, frame_len 1 and 0.
    got_q.delete();
    beat(98304, 1);
    @(negedge clk);
    chk("latency_out_vld", longint'(out_vld), 1);
    sync();
    beat(98304, 0);
    wait_got(2);
    lit("single_len1", 0, 3, 0);
    lit("single_len0", 1, 3, 0);

    // Rounding at the half-LSB boundary.
    got_q.delete();
    beat(16384, 2);  beat(0, 2);
    beat(-16385, 2); beat(0, 2);
    beat(-16384, 2); beat(0, 2);
    wait_got(3);
    lit("round_pos_half", 0, 1, 0);
    lit("round_neg_over", 1, -1, 0);
    lit("round_neg_half", 2, 0, 0);

    // Saturation both ways.
    got_q.delete();
    repeat (4) beat(64'sd1 <<< 30, 4);
    repeat (4) beat(-(64'sd1 <<< 30), 4);
    wait_got(2);
    lit("sat_pos", 0, 32767, 1);
    lit("sat_neg", 1, -32768, 1);

    // Back-pressure: buffer fills, head held, then drains in order.
    got_q.delete();
    out_rdy = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) beat(longint'(k) * 32768, 1);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_in_rdy", longint'(in_rdy), 0);
        chk("bp_out_vld", longint'(out_vld), 1);
        chk("bp_head", longint'(signed'(out_data)), 1);
        repeat (3) @(negedge clk);
        chk("bp_head_hold", longint'(signed'(out_data)), 1);
        sync();
        out_rdy = 1'b1;
      end
    join
    wait_got(4);
    for (int k = 0; k < 4; k++) lit("bp_order", k, k + 1, 0);
    chk("bp_count", longint'(got_q.size()), 4);

    // Gapped frame.
    got_q.delete();
    beat(32768, 3);
    @(negedge clk);
    chk("gap_busy", longint'(busy), 1);
    sync();
    idle(1);
    beat(32768, 3);
    idle(2);
    beat(32768, 3);
    wait_got(1);
    lit("gap_frame", 0, 3, 0);

    // Mid-frame reset discards the partial sum.
    got_q.delete();
    beat(32768, 4);
    beat(32768, 4);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_out_vld", longint'(out_vld), 0);
    sync();
    beat(5 * 32768, 1);
    wait_got(1);
    lit("after_rst", 0, 5, 0);
    chk("after_rst_count", longint'(got_q.size()), 1);

    // Randomized frames with random stalls and gaps; later beats carry a
    // random frame_len that must be ignored.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 80; f++) begin
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 20) : $urandom_range(0, 5);
      nb = (fl == 0) ? 1 : fl;
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 3))
          0: d = longint'($urandom_range(0, 131072)) - 65536;
          1: d = longint'($urandom_range(0, 32768)) - 16384;
          2: begin
            raw = {$urandom(), $urandom()};
            r48 = raw[47:0];
            d   = longint'(r48);
          end
          default: d = longint'($urandom_range(0, 32'h7fff_ffff)) - 64'sd1073741824;
        endcase
        beat(d, (b == 0) ? fl : int'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    rnd_rdy = 1'b0;
    sync();
    out_rdy = 1'b1;
    t = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        timeout("drain");
        break;
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_frame_accum.md
Name: mac_frame_accum

Overview:
- Downstream consumer of the multiply-add stage (p = a*b + c).
- Accumulates a frame of signed 48-bit products (pout), rounds and scales the sum by a right shift, saturates it to a 16-bit output sample, and hands it out through a valid/ready interface.
- A 2-entry output buffer absorbs output stalls; upstream is back-pressured through in_rdy.

Parameters:
- PW, 48, input product width (matches multiply-add PW)
- AW_ACC, 56, accumulator width (PW + 8 guard bits)
- OW, 16, output sample width
- SHIFT, 15, right shift applied before saturation (1..AW_ACC-OW)
- LW, 8, width of frame-length input

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_vld  input  1  din valid (upstream ce delayed by multiply-add latency)
- in_rdy  output  1  block can accept din this cycle
- din  input  PW  signed product from multiply-add stage
- frame_len  input  LW  samples per frame; sampled at first beat of each frame
- out_vld  output  1  out_data valid
- out_rdy  input  1  downstream accepts out_data
- out_data  output  OW  signed rounded/saturated frame sum
- out_sat  output  1  out_data was saturated (travels with the sample)
- busy  output  1  a frame is partially accumulated

Behaviour:
- Reset: acc=0, cnt=0, state IDLE, buffer empty.
  - Outputs: out_vld=0, out_data=0, out_sat=0, busy=0.
  - in_rdy=1 from the first cycle after reset.
- Reset mid-frame: partial sum discarded; buffered outputs are dropped.
- Accept condition: a beat is accepted when in_vld && in_rdy.
- in_rdy = buffer occupancy < 2. This is combinational from registered occupancy only; it does not depend on out_rdy.
- State IDLE, on an accepted beat:
  - Latch len = max(frame_len, 1).
  - If len==1, the frame completes immediately.
  - Otherwise acc=sext(din), cnt=1, go to ACC.
- State ACC, on an accepted beat:
  - If cnt==len-1, the frame completes.
  - Otherwise acc+=sext(din), cnt++.
- No beat accepted: state, acc and cnt hold. Gaps in in_vld are allowed anywhere inside a frame.
- Frame complete: computed in the cycle of the last beat.
  - Sum: s = acc_next (acc + din; just sext(din) when len==1).
  - Round half-up: r = (s + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, done at AW_ACC+1 bits so the rounding add cannot wrap.
  - Saturate r to [-2^(OW-1), 2^(OW-1)-1]; sat = 1 if clipped.
  - Push {data, sat} into the buffer at the clock edge; return to IDLE with acc=0, cnt=0.
- Latency: out_vld rises the cycle after the last beat is accepted, when the buffer was empty.
- Accumulator: wraps modulo 2^AW_ACC with no overflow detection. Sized for up to 256 full-scale products.
- Output buffer: 2-entry FIFO; the head drives out_data/out_sat and out_vld = not empty.
  - Pop on out_vld && out_rdy.
  - Push and pop in the same cycle: occupancy unchanged, order preserved.
  - Push is only possible when occupancy < 2, so no overflow can occur.
  - A pop from empty is impossible because out_vld=0.
  - out_data and out_sat hold steady while out_vld && !out_rdy.
- busy = (state==ACC).
- frame_len changes mid-frame have no effect until the next frame start.

Decomposition:
- Package mac_frame_pkg:
  - typedef state_t {IDLE, ACC}
  - function sat_round(s) returning {sat, data}
  - localparams for default widths and the ROUND constant 2^(SHIFT-1)
- One sub-module, mac_out_fifo2: parameterised-width 2-entry FIFO with push, pop, occupancy, and head outputs.

Test Plan:
- Single-beat frame: frame_len=1, din=3*2^15 (98304) -> one cycle later out_data=3, out_sat=0. Also frame_len=0 with the same din -> identical result.
- Rounding: frame_len=2, din=16384 then 0 -> out_data=1 (0.5 rounds up). din=-16385 then 0 -> out_data=-1. din=-16384 then 0 -> out_data=0.
- Saturation: frame_len=4, din=2^30 each beat -> out_data=32767, out_sat=1. din=-2^30 each beat -> out_data=-32768, out_sat=1.
- Back-pressure:
  - Stimulus: out_rdy=0, frame_len=1, four consecutive beats din=k*2^15 for k=1..4.
  - Required: in_rdy falls after two results are buffered. out_data=1 is held stable.
  - Then raise out_rdy: outputs appear in order 1,2,3,4 with no loss or duplication.
- Gapped frame: frame_len=3, beats 2^15, 2^15, 2^15 with in_vld low for 2 cycles between them -> out_data=3, with busy=1 between the first and last beat.
- Mid-frame reset: frame_len=4, two beats accepted, then rst for 1 cycle -> busy=0, out_vld=0. A following frame_len=1 frame with din=5*2^15 -> out_data=5.
